// File: rtl/stopwatch_pkg.sv
// Shared types and constants for the stopwatch timekeeping core.
package stopwatch_pkg;

  // Control state of the stopwatch.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_PAUSE = 2'd2,
    ST_LAP   = 2'd3
  } state_t;

  // Per-field rollover limits of the BCD chain.
  localparam int unsigned CC_MOD = 100;
  localparam int unsigned SS_MOD = 60;
  localparam int unsigned MM_MOD = 60;

  localparam int unsigned DIGIT_W    = 4;
  localparam int unsigned FIELD_W    = 8;
  localparam int unsigned NUM_DIGITS = 8;
  localparam int unsigned DIGITS_W   = DIGIT_W * NUM_DIGITS;

  // Digit positions inside the 32-bit display word (0 = least significant).
  localparam int unsigned DIG_HT = 7;
  localparam int unsigned DIG_HU = 6;
  localparam int unsigned DIG_MT = 5;
  localparam int unsigned DIG_MU = 4;
  localparam int unsigned DIG_ST = 3;
  localparam int unsigned DIG_SU = 2;
  localparam int unsigned DIG_CT = 1;
  localparam int unsigned DIG_CU = 0;

  // Time value as four two-digit BCD fields, HH in the top byte.
  typedef struct packed {
    logic [FIELD_W-1:0] hh;
    logic [FIELD_W-1:0] mm;
    logic [FIELD_W-1:0] ss;
    logic [FIELD_W-1:0] cc;
  } bcd_time_t;

  // Extract one BCD digit from a display word.
  function automatic logic [DIGIT_W-1:0] digit_at(input logic [DIGITS_W-1:0] d,
                                                   input int unsigned idx);
    return DIGIT_W'(d >> (DIGIT_W * idx));
  endfunction

endpackage

// File: rtl/stopwatch_core_if.sv
// Control pulses into, and display/status out of, the stopwatch core.
interface stopwatch_core_if;
  import stopwatch_pkg::*;

  logic                tick;
  logic                start_stop;
  logic                lap;
  logic                clr;
  logic [DIGITS_W-1:0] digits;
  logic                running;
  logic                lap_hold;
  logic                wrap;

  // Button/tick source side.
  modport master (
    output tick, start_stop, lap, clr,
    input  digits, running, lap_hold, wrap
  );

  // Stopwatch core side.
  modport slave (
    input  tick, start_stop, lap, clr,
    output digits, running, lap_hold, wrap
  );

endinterface

// File: rtl/bcd_mod_cnt.sv
// Two-digit BCD counter that wraps at MOD; carry flags the wrapping increment.
module bcd_mod_cnt #(
  parameter int unsigned MOD = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clr,
  input  logic       inc,
  output logic [7:0] val,
  output logic       carry
);

  // Terminal value MOD-1 in BCD.
  localparam logic [7:0] LAST = {4'((MOD - 1) / 10), 4'((MOD - 1) % 10)};

  logic [7:0] r_val;
  logic [7:0] w_val_nxt;

  // BCD successor of the current value, folding back to zero at the terminal value.
  always_comb begin
    w_val_nxt = r_val;
    if (r_val == LAST) begin
      w_val_nxt = 8'h00;
    end else if (r_val[3:0] == 4'd9) begin
      w_val_nxt = {r_val[7:4] + 4'd1, 4'd0};
    end else begin
      w_val_nxt = {r_val[7:4], r_val[3:0] + 4'd1};
    end
  end

  // Count register; clear dominates increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_val <= 8'h00;
    end else if (clr) begin
      r_val <= 8'h00;
    end else if (inc) begin
      r_val <= w_val_nxt;
    end
  end

  assign val   = r_val;
  assign carry = inc && (r_val == LAST);

endmodule

// File: rtl/stopwatch_core.sv
// Stopwatch core: HH:MM:SS.CC BCD chain, run/pause/lap/clear control,
// lap snapshot and registered display mux.
module stopwatch_core
  import stopwatch_pkg::*;
#(
  parameter int unsigned HOUR_MOD = 24
) (
  input  logic             clk,
  input  logic             rst,
  stopwatch_core_if.slave  bus
);

  state_t              r_state;
  state_t              w_state_nxt;

  logic                w_cnt_en;
  logic                w_snap_load;
  logic                w_running_nxt;
  logic                w_lap_hold_nxt;

  logic [FIELD_W-1:0]  w_cc;
  logic [FIELD_W-1:0]  w_ss;
  logic [FIELD_W-1:0]  w_mm;
  logic [FIELD_W-1:0]  w_hh;
  logic                w_cc_carry;
  logic                w_ss_carry;
  logic                w_mm_carry;
  logic                w_hh_carry;

  bcd_time_t           w_count;
  bcd_time_t           r_snap;
  logic [DIGITS_W-1:0] r_digits;
  logic                r_running;
  logic                r_lap_hold;
  logic                r_wrap;

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: clr beats start_stop, which beats lap.
  always_comb begin
    w_state_nxt = r_state;
    if (bus.clr) begin
      w_state_nxt = ST_IDLE;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (bus.start_stop) w_state_nxt = ST_RUN;
        end
        ST_RUN: begin
          if (bus.start_stop)   w_state_nxt = ST_PAUSE;
          else if (bus.lap)     w_state_nxt = ST_LAP;
        end
        ST_LAP: begin
          if (bus.start_stop)   w_state_nxt = ST_PAUSE;
          else if (bus.lap)     w_state_nxt = ST_RUN;
        end
        ST_PAUSE: begin
          if (bus.start_stop)   w_state_nxt = ST_RUN;
        end
        default: w_state_nxt = ST_IDLE;
      endcase
    end
  end

  // Control decode; counting follows the state held at the start of the cycle.
  always_comb begin
    w_cnt_en       = 1'b0;
    w_snap_load    = 1'b0;
    w_running_nxt  = 1'b0;
    w_lap_hold_nxt = 1'b0;
    if (!bus.clr) begin
      w_cnt_en    = bus.tick && ((r_state == ST_RUN) || (r_state == ST_LAP));
      w_snap_load = (r_state == ST_RUN) && bus.lap && !bus.start_stop;
    end
    w_running_nxt  = (w_state_nxt == ST_RUN) || (w_state_nxt == ST_LAP);
    w_lap_hold_nxt = (w_state_nxt == ST_LAP);
  end

  // Hundredths -> seconds -> minutes -> hours, carries ripple within the tick cycle.
  bcd_mod_cnt #(.MOD(CC_MOD)) u_cc (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.clr),
    .inc   (w_cnt_en),
    .val   (w_cc),
    .carry (w_cc_carry)
  );

  bcd_mod_cnt #(.MOD(SS_MOD)) u_ss (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.clr),
    .inc   (w_cc_carry),
    .val   (w_ss),
    .carry (w_ss_carry)
  );

  bcd_mod_cnt #(.MOD(MM_MOD)) u_mm (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.clr),
    .inc   (w_ss_carry),
    .val   (w_mm),
    .carry (w_mm_carry)
  );

  bcd_mod_cnt #(.MOD(HOUR_MOD)) u_hh (
    .clk   (clk),
    .rst   (rst),
    .clr   (bus.clr),
    .inc   (w_mm_carry),
    .val   (w_hh),
    .carry (w_hh_carry)
  );

  assign w_count = {w_hh, w_mm, w_ss, w_cc};

  // Lap snapshot captures the pre-increment count on entry to LAP.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_snap <= '0;
    end else if (bus.clr) begin
      r_snap <= '0;
    end else if (w_snap_load) begin
      r_snap <= w_count;
    end
  end

  // Registered status flags and rollover pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_running  <= 1'b0;
      r_lap_hold <= 1'b0;
      r_wrap     <= 1'b0;
    end else begin
      r_running  <= w_running_nxt;
      r_lap_hold <= w_lap_hold_nxt;
      r_wrap     <= w_hh_carry;
    end
  end

  // Display word: frozen snapshot while in LAP, otherwise the live count.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_digits <= '0;
    end else begin
      r_digits <= r_lap_hold ? DIGITS_W'(r_snap) : DIGITS_W'(w_count);
    end
  end

  assign bus.digits   = r_digits;
  assign bus.running  = r_running;
  assign bus.lap_hold = r_lap_hold;
  assign bus.wrap     = r_wrap;

endmodule

// File: tb/tb_stopwatch_core.sv
// Directed bench for stopwatch_core with an elapsed-hundredths reference model.
module tb_stopwatch_core;
  import stopwatch_pkg::*;

  localparam int unsigned TB_HOUR_MOD = 24;
  localparam int unsigned DAY_CC      = TB_HOUR_MOD * 360000;
  localparam int unsigned PRELOAD_CC  = DAY_CC - 1;

  localparam int unsigned M_IDLE  = 0;
  localparam int unsigned M_RUN   = 1;
  localparam int unsigned M_PAUSE = 2;
  localparam int unsigned M_LAP   = 3;

  typedef struct {
    int unsigned cnt;
    int unsigned snap;
    int unsigned st;
    logic [31:0] digits;
    logic        running;
    logic        lap;
    logic        wrap;
  } model_t;

  logic   clk = 1'b0;
  logic   rst_n;
  logic   preload_go;
  model_t m;
  int     n_chk = 0;
  int     n_err = 0;

  stopwatch_core_if sw_if ();

  stopwatch_core #(.HOUR_MOD(TB_HOUR_MOD)) dut (
    .clk (clk),
    .rst (rst_n),
    .bus (sw_if)
  );

  always #5 clk = ~clk;

  // Elapsed hundredths -> HH MM SS CC BCD word.
  function automatic logic [31:0] to_bcd(input int unsigned t);
    int unsigned h, mi, s, c;
    c  = t % 100;
    s  = (t / 100) % 60;
    mi = (t / 6000) % 60;
    h  = t / 360000;
    return {4'(h / 10), 4'(h % 10), 4'(mi / 10), 4'(mi % 10),
            4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
  endfunction

  // One clock of the reference behaviour.
  function automatic model_t step(input model_t cur, input logic t, input logic s,
                                  input logic l, input logic c, input logic pre);
    model_t o;
    model_t n;
    logic   counting;
    o = cur;
    if (pre) o.cnt = PRELOAD_CC;
    n = o;
    n.digits = to_bcd(o.st == M_LAP ? o.snap : o.cnt);
    counting = t && (o.st == M_RUN || o.st == M_LAP) && !c;
    n.wrap   = counting && (o.cnt == DAY_CC - 1);
    if (c) begin
      n.st = M_IDLE; n.cnt = 0; n.snap = 0;
    end else begin
      if (counting) n.cnt = (o.cnt + 1) % DAY_CC;
      case (o.st)
        M_IDLE:  if (s) n.st = M_RUN;
        M_RUN:   if (s) n.st = M_PAUSE;
                 else if (l) begin n.st = M_LAP; n.snap = o.cnt; end
        M_LAP:   if (s) n.st = M_PAUSE; else if (l) n.st = M_RUN;
        default: if (s) n.st = M_RUN;
      endcase
    end
    n.running = (n.st == M_RUN) || (n.st == M_LAP);
    n.lap     = (n.st == M_LAP);
    return n;
  endfunction

  // Reference state, reset asynchronously like the DUT.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      m <= '{cnt: 0, snap: 0, st: M_IDLE, digits: '0, running: 1'b0, lap: 1'b0, wrap: 1'b0};
    else
      m <= step(m, sw_if.tick, sw_if.start_stop, sw_if.lap, sw_if.clr, preload_go);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_model();
    chk("model_digits",   sw_if.digits,          m.digits);
    chk("model_running",  32'(sw_if.running),    32'(m.running));
    chk("model_lap_hold", 32'(sw_if.lap_hold),   32'(m.lap));
    chk("model_wrap",     32'(sw_if.wrap),       32'(m.wrap));
  endtask

  // One clock: drive inputs, compare at the falling edge, return just after the rising edge.
  task automatic cyc(input logic t, input logic s, input logic l, input logic c);
    sw_if.tick       = t;
    sw_if.start_stop = s;
    sw_if.lap        = l;
    sw_if.clr        = c;
    @(negedge clk);
    check_model();
    @(posedge clk);
    #2;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic idle();
    cyc(1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    rst_n            = 1'b0;
    preload_go       = 1'b0;
    sw_if.tick       = 1'b0;
    sw_if.start_stop = 1'b0;
    sw_if.lap        = 1'b0;
    sw_if.clr        = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    chk("reset_digits",  sw_if.digits, 32'h0);
    chk("reset_running", 32'(sw_if.running), 32'h0);
    chk("reset_wrap",    32'(sw_if.wrap), 32'h0);
    rst_n = 1'b1;

    // Run 150 hundredths.
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(150);
    idle();
    chk("run150_digits",  sw_if.digits, 32'h0000_0150);
    chk("run150_running", 32'(sw_if.running), 32'h1);

    // Seconds into minutes.
    ticks(5849);
    idle();
    chk("pre_minute", sw_if.digits, 32'h0000_5999);
    ticks(1);
    idle();
    chk("minute_carry", sw_if.digits, 32'h0001_0000);

    // Lap freeze and release.
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(42);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("lap_hold_set", 32'(sw_if.lap_hold), 32'h1);
    ticks(10);
    idle();
    chk("lap_frozen", sw_if.digits, 32'h0000_0042);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    chk("lap_release",  sw_if.digits, 32'h0000_0052);
    chk("lap_hold_clr", 32'(sw_if.lap_hold), 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    ticks(3);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    chk("lap_to_pause", sw_if.digits, 32'h0000_0055);
    chk("lap_to_pause_running", 32'(sw_if.running), 32'h0);

    // start_stop coinciding with tick.
    cyc(1'b0, 1'b0, 1'b0, 1'b1);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(7);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    chk("stop_tick_digits",  sw_if.digits, 32'h0000_0008);
    chk("stop_tick_running", 32'(sw_if.running), 32'h0);
    ticks(5);
    idle();
    chk("paused_ignores", sw_if.digits, 32'h0000_0008);
    cyc(1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    chk("resume_tick_uncounted", sw_if.digits, 32'h0000_0008);
    chk("resume_running", 32'(sw_if.running), 32'h1);
    cyc(1'b0, 1'b1, 1'b0, 1'b1);
    idle();
    chk("clr_ss_digits",  sw_if.digits, 32'h0);
    chk("clr_ss_running", 32'(sw_if.running), 32'h0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0);
    chk("idle_lap_ignored", 32'(sw_if.lap_hold), 32'h0);

    // Full-day rollover from 23:59:59.99.
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    force dut.u_hh.r_val = 8'h23;
    force dut.u_mm.r_val = 8'h59;
    force dut.u_ss.r_val = 8'h59;
    force dut.u_cc.r_val = 8'h99;
    preload_go = 1'b1;
    idle();
    preload_go = 1'b0;
    release dut.u_hh.r_val;
    release dut.u_mm.r_val;
    release dut.u_ss.r_val;
    release dut.u_cc.r_val;
    idle();
    chk("preload_digits", sw_if.digits, 32'h2359_5999);
    chk("preload_hour_tens", 32'(digit_at(sw_if.digits, DIG_HT)), 32'h2);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0);
    chk("wrap_pulse", 32'(sw_if.wrap), 32'h1);
    idle();
    chk("wrap_one_cycle", 32'(sw_if.wrap), 32'h0);
    chk("wrap_digits",    sw_if.digits, 32'h0);

    // Asynchronous reset between clock edges.
    ticks(5);
    sw_if.tick = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_digits",   sw_if.digits, 32'h0);
    chk("async_rst_running",  32'(sw_if.running), 32'h0);
    chk("async_rst_lap_hold", 32'(sw_if.lap_hold), 32'h0);
    chk("async_rst_wrap",     32'(sw_if.wrap), 32'h0);
    @(posedge clk);
    #2;
    ticks(2);
    rst_n = 1'b1;
    ticks(5);
    idle();
    chk("post_rst_no_count", sw_if.digits, 32'h0);
    chk("post_rst_running",  32'(sw_if.running), 32'h0);
    cyc(1'b0, 1'b1, 1'b0, 1'b0);
    ticks(3);
    idle();
    chk("post_rst_restart", sw_if.digits, 32'h0000_0003);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
